wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries per source FIFO; legal range 1 to 8.
REQ-002 Parameter STARVE_LIMIT, default 4: ALU lost-arbitration count that forces an ALU grant; legal range 1 to 15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_alu_valid  input  1  ALU completion offered.
REQ-006 i_alu_uop  input  uop_t  ALU completion uop.
REQ-007 i_alu_result  input  32  ALU result.
REQ-008 o_alu_ready  output  1  ALU FIFO can accept.
REQ-009 i_lsu_valid  input  1  LSU completion offered.
REQ-010 i_lsu_uop  input  uop_t  LSU completion uop.
REQ-011 i_lsu_load_data  input  32  LSU load data.
REQ-012 o_lsu_ready  output  1  LSU FIFO can accept.
REQ-013 i_flush  input  1  synchronous squash of all held completions.
REQ-014 i_stall  input  1  retire stall: hold output, no pop.
REQ-015 o_ret_valid  output  1  registered completion to retire.
REQ-016 o_ret_uop  output  uop_t  registered uop to retire.
REQ-017 o_ret_data  output  32  registered result to retire.
REQ-018 o_busy  output  1  any FIFO entry or output register valid.
REQ-019 o_conflict_cnt  output  16  saturating count of contended grant cycles.

Function
REQ-020 Per-source FIFO: DEPTH entries holding {uop, data}; push when valid && ready && !i_flush; in-order pop from the head.
REQ-021 Ready = (registered count < DEPTH), independent of a same-cycle pop; full FIFO deasserts ready even while popping.
REQ-022 Simultaneous push and pop on one FIFO leaves count unchanged; pointers wrap modulo DEPTH.
REQ-023 Arbitration occurs only in cycles with !i_stall && !i_flush.
REQ-024 If both heads are valid: grant LSU unless alu_wait >= STARVE_LIMIT, in which case grant ALU.
REQ-025 If only one head is valid, grant it; the winner pops exactly one entry.
REQ-026 On a grant, the output register loads {1, head uop, head data} at the next edge.
REQ-027 On an arbitration cycle with no heads valid, o_ret_valid becomes 0 and uop/data become 0.
REQ-028 While i_stall=1 (and no flush): output register, FIFOs (except pushes), alu_wait and o_conflict_cnt hold.
REQ-029 alu_wait (4-bit): +1, saturating at STARVE_LIMIT, on each arbitration cycle where the ALU head is valid and the LSU is granted.
REQ-030 alu_wait: cleared when the ALU is granted or the ALU FIFO is empty; held during stall cycles.
REQ-031 o_conflict_cnt: +1 on each arbitration cycle with both heads valid; saturates at 16'hFFFF; not cleared by flush.
REQ-032 Latency: a push into an empty FIFO, uncontended and unstalled, appears on o_ret_valid 2 edges later (push edge, then grant edge).
REQ-033 i_flush=1 at an edge: both FIFOs emptied, output register cleared, alu_wait=0, that cycle's pushes dropped; flush overrides stall.
REQ-034 o_busy = o_ret_valid || alu_count != 0 || lsu_count != 0 (combinational from state).

Reset
REQ-035 rst_n=0, asynchronously: FIFOs empty, o_ret_valid=0, o_ret_uop='0, o_ret_data=0, alu_wait=0, o_conflict_cnt=0.
REQ-036 During reset: o_alu_ready=1, o_lsu_ready=1, o_busy=0.
REQ-037 Reset asserted mid-operation discards all held entries; no completion is emitted after release until a new push.

Verification
REQ-038 Single ALU push (rd=5, result=32'h1234), no stall -> o_ret_valid=1, rd=5, data=32'h1234 exactly 2 edges after push; o_busy then 0 one edge after drain.
REQ-039 ALU and LSU push the same cycle (ALU rd=1, LSU rd=2) -> LSU emitted first, ALU next cycle; o_conflict_cnt increments by 1.
REQ-040 ALU FIFO held non-empty while LSU pushes every cycle, STARVE_LIMIT=4 -> LSU wins 4 grants, ALU granted on the 5th contended cycle, then alu_wait=0.
REQ-041 Hold i_stall=1 and push 2 entries per source (DEPTH=2) -> both readys 0 after 2 pushes, output holds its value; release stall -> 4 completions drain in order LSU,LSU,ALU,ALU.
REQ-042 Both FIFOs full, output valid, assert i_flush with i_alu_valid=1 -> next edge o_ret_valid=0, o_busy=0, readys=1, flushed-cycle push absent.
REQ-043 Assert rst_n=0 mid-drain for 1 cycle -> outputs take reset values immediately; o_conflict_cnt=0; no stale completion after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Completion arbiter: buffers ALU and LSU completions in small FIFOs and
// retires one per cycle through a registered output, LSU-first with ALU starvation relief.
package wb_arbiter_pkg;
    typedef struct packed {
        logic [4:0] rd;
        logic [7:0] tag;
    } uop_t;
endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_alu_valid,
    input  uop_t        i_alu_uop,
    input  logic [31:0] i_alu_result,
    output logic        o_alu_ready,
    input  logic        i_lsu_valid,
    input  uop_t        i_lsu_uop,
    input  logic [31:0] i_lsu_load_data,
    output logic        o_lsu_ready,
    input  logic        i_flush,
    input  logic        i_stall,
    output logic        o_ret_valid,
    output uop_t        o_ret_uop,
    output logic [31:0] o_ret_data,
    output logic        o_busy,
    output logic [15:0] o_conflict_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(uop_t) + 32;

    // Source index 0 is the ALU, 1 is the LSU.
    logic [1:0]         in_valid;
    logic [1:0]         in_ready;
    logic [1:0]         head_valid;
    logic [1:0]         grant;
    logic [1:0][EW-1:0] in_entry;
    logic [1:0][EW-1:0] head_entry;
    logic [1:0][CW-1:0] count;

    assign in_valid    = {i_lsu_valid, i_alu_valid};
    assign in_entry[0] = {i_alu_uop, i_alu_result};
    assign in_entry[1] = {i_lsu_uop, i_lsu_load_data};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [EW-1:0] mem [DEPTH];
            logic [PW-1:0] wr_ptr_q, wr_ptr_d;
            logic [PW-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0] count_q, count_d;
            logic          push;
            logic          pop;

            // Ready looks only at the registered count, so a full FIFO refuses
            // a push even in a cycle where it is also being popped.
            assign in_ready[gi] = (count_q < CW'(DEPTH));
            assign push         = in_valid[gi] && in_ready[gi] && !i_flush;
            assign pop          = grant[gi];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (i_flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push) begin
                        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   count_d = count_q + 1'b1;
                        2'b01:   count_d = count_q - 1'b1;
                        default: count_d = count_q;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Storage carries no reset; validity is tracked by count_q alone.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_q] <= in_entry[gi];
                end
            end

            assign head_valid[gi] = (count_q != '0);
            assign head_entry[gi] = mem[rd_ptr_q];
            assign count[gi]      = count_q;
        end
    endgenerate

    logic        arb;
    logic        both;
    logic [3:0]  alu_wait_q, alu_wait_d;
    logic        ret_valid_q, ret_valid_d;
    uop_t        ret_uop_q, ret_uop_d;
    logic [31:0] ret_data_q, ret_data_d;
    logic [15:0] conflict_q, conflict_d;

    assign arb  = !i_stall && !i_flush;
    assign both = &head_valid;

    always_comb begin
        grant = '0;
        if (arb) begin
            if (head_valid[0] && (!head_valid[1] || alu_wait_q >= 4'(STARVE_LIMIT))) begin
                grant[0] = 1'b1;
            end else if (head_valid[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    always_comb begin
        ret_valid_d = ret_valid_q;
        ret_uop_d   = ret_uop_q;
        ret_data_d  = ret_data_q;
        alu_wait_d  = alu_wait_q;
        conflict_d  = conflict_q;
        if (i_flush) begin
            ret_valid_d = 1'b0;
            ret_uop_d   = '0;
            ret_data_d  = '0;
            alu_wait_d  = '0;
        end else if (arb) begin
            if (grant[0]) begin
                ret_valid_d             = 1'b1;
                {ret_uop_d, ret_data_d} = head_entry[0];
            end else if (grant[1]) begin
                ret_valid_d             = 1'b1;
                {ret_uop_d, ret_data_d} = head_entry[1];
            end else begin
                ret_valid_d = 1'b0;
                ret_uop_d   = '0;
                ret_data_d  = '0;
            end
            if (grant[0] || !head_valid[0]) begin
                alu_wait_d = '0;
            end else if (grant[1] && alu_wait_q < 4'(STARVE_LIMIT)) begin
                alu_wait_d = alu_wait_q + 1'b1;
            end
            if (both && conflict_q != 16'hFFFF) begin
                conflict_d = conflict_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid_q <= 1'b0;
            ret_uop_q   <= '0;
            ret_data_q  <= '0;
            alu_wait_q  <= '0;
            conflict_q  <= '0;
        end else begin
            ret_valid_q <= ret_valid_d;
            ret_uop_q   <= ret_uop_d;
            ret_data_q  <= ret_data_d;
            alu_wait_q  <= alu_wait_d;
            conflict_q  <= conflict_d;
        end
    end

    assign o_alu_ready    = in_ready[0];
    assign o_lsu_ready    = in_ready[1];
    assign o_ret_valid    = ret_valid_q;
    assign o_ret_uop      = ret_uop_q;
    assign o_ret_data     = ret_data_q;
    assign o_conflict_cnt = conflict_q;
    assign o_busy         = ret_valid_q || (count[0] != '0) || (count[1] != '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario bench for wb_arbiter: expected completions are queued as stimulus
// is driven and compared in order as the retire port produces them.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_alu_valid, i_lsu_valid, i_flush, i_stall;
    uop_t        i_alu_uop, i_lsu_uop;
    logic [31:0] i_alu_result, i_lsu_load_data;
    logic        o_alu_ready, o_lsu_ready, o_ret_valid, o_busy;
    uop_t        o_ret_uop;
    logic [31:0] o_ret_data;
    logic [15:0] o_conflict_cnt;

    typedef struct packed {
        uop_t        uop;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_alu_valid    (i_alu_valid),
        .i_alu_uop      (i_alu_uop),
        .i_alu_result   (i_alu_result),
        .o_alu_ready    (o_alu_ready),
        .i_lsu_valid    (i_lsu_valid),
        .i_lsu_uop      (i_lsu_uop),
        .i_lsu_load_data(i_lsu_load_data),
        .o_lsu_ready    (o_lsu_ready),
        .i_flush        (i_flush),
        .i_stall        (i_stall),
        .o_ret_valid    (o_ret_valid),
        .o_ret_uop      (o_ret_uop),
        .o_ret_data     (o_ret_data),
        .o_busy         (o_busy),
        .o_conflict_cnt (o_conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic uop_t mk_uop(input logic [4:0] rd, input logic [7:0] tag);
        uop_t u;
        u.rd  = rd;
        u.tag = tag;
        return u;
    endfunction

    task automatic idle();
        i_alu_valid     = 1'b0;
        i_lsu_valid     = 1'b0;
        i_alu_uop       = '0;
        i_lsu_uop       = '0;
        i_alu_result    = '0;
        i_lsu_load_data = '0;
        i_flush         = 1'b0;
        i_stall         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        i_alu_valid  = 1'b1;
        i_alu_uop    = mk_uop(rd, 8'hA0 + 8'(rd));
        i_alu_result = data;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data);
        i_lsu_valid     = 1'b1;
        i_lsu_uop       = mk_uop(rd, 8'h50 + 8'(rd));
        i_lsu_load_data = data;
    endtask

    function automatic exp_t mk_alu_exp(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.uop  = mk_uop(rd, 8'hA0 + 8'(rd));
        e.data = data;
        return e;
    endfunction

    function automatic exp_t mk_lsu_exp(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.uop  = mk_uop(rd, 8'h50 + 8'(rd));
        e.data = data;
        return e;
    endfunction

    task automatic test_reset();
        idle();
        rst_n       = 1'b0;
        i_alu_valid = 1'b1;
        i_lsu_valid = 1'b1;
        #1;
        checks++;
        if (o_ret_valid !== 1'b0 || o_ret_data !== 32'h0 || o_ret_uop !== uop_t'(0)) begin
            errors++;
            $display("FAIL reset_output: valid=%b data=%h uop=%h, want 0/0/0", o_ret_valid, o_ret_data, o_ret_uop);
        end
        checks++;
        if (o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: alu_rdy=%b lsu_rdy=%b busy=%b, want 1/1/0", o_alu_ready, o_lsu_ready, o_busy);
        end
        checks++;
        if (o_conflict_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_conflict: cnt=%0d, want 0", o_conflict_cnt);
        end
        tick();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_ret_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b valid=%b, want 0/0", o_busy, o_ret_valid);
        end
    endtask

    task automatic test_single();
        exp_t e;
        drive_alu(5'd5, 32'h1234);
        sb.push_back(mk_alu_exp(5'd5, 32'h1234));
        tick();
        idle();
        checks++;
        if (o_ret_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_push_edge: valid=%b busy=%b, want 0/1", o_ret_valid, o_busy);
        end
        tick();
        checks++;
        if (o_ret_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: valid=%b two edges after push, want 1", o_ret_valid);
        end else begin
            e = sb.pop_front();
            if (o_ret_uop !== e.uop || o_ret_data !== e.data) begin
                errors++;
                $display("FAIL single_data: rd=%0d data=%h, want rd=%0d data=%h", o_ret_uop.rd, o_ret_data, e.uop.rd, e.data);
            end
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_ret_valid !== 1'b0 || o_ret_data !== 32'h0) begin
            errors++;
            $display("FAIL single_drain: busy=%b valid=%b data=%h, want 0/0/0", o_busy, o_ret_valid, o_ret_data);
        end
        sb.delete();
    endtask

    task automatic test_contention();
        exp_t e;
        logic [15:0] c0;
        c0 = o_conflict_cnt;
        drive_alu(5'd1, 32'hAAAA_0001);
        drive_lsu(5'd2, 32'h5555_0002);
        sb.push_back(mk_lsu_exp(5'd2, 32'h5555_0002));
        sb.push_back(mk_alu_exp(5'd1, 32'hAAAA_0001));
        tick();
        idle();
        for (int c = 0; c < 8 && sb.size() != 0; c++) begin
            tick();
            if (o_ret_valid) begin
                e = sb.pop_front();
                checks++;
                if (o_ret_uop !== e.uop || o_ret_data !== e.data) begin
                    errors++;
                    $display("FAIL contention_order: rd=%0d data=%h, want rd=%0d data=%h", o_ret_uop.rd, o_ret_data, e.uop.rd, e.data);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL contention_timeout: %0d completions missing, want 0", sb.size());
            sb.delete();
        end
        checks++;
        if (o_conflict_cnt !== c0 + 16'd1) begin
            errors++;
            $display("FAIL contention_count: cnt=%0d, want %0d", o_conflict_cnt, c0 + 16'd1);
        end
        tick();
    endtask

    task automatic test_starve();
        exp_t e;
        int   lsu_grants;
        lsu_grants = 0;
        for (int i = 0; i < 4; i++) sb.push_back(mk_lsu_exp(5'(10 + i), 32'h100 + i));
        sb.push_back(mk_alu_exp(5'd7, 32'h0777));
        for (int i = 4; i < 6; i++) sb.push_back(mk_lsu_exp(5'(10 + i), 32'h100 + i));
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c == 0) drive_alu(5'd7, 32'h0777);
            if (c < 6) drive_lsu(5'(10 + c), 32'h100 + c);
            tick();
            if (o_ret_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL starve_extra: unexpected rd=%0d, want no completion", o_ret_uop.rd);
                end else begin
                    e = sb.pop_front();
                    if (o_ret_uop !== e.uop || o_ret_data !== e.data) begin
                        errors++;
                        $display("FAIL starve_order: rd=%0d data=%h, want rd=%0d data=%h", o_ret_uop.rd, o_ret_data, e.uop.rd, e.data);
                    end
                    if (o_ret_uop.rd == 5'd7) begin
                        checks++;
                        if (lsu_grants != 4 || dut.alu_wait_q !== 4'd0) begin
                            errors++;
                            $display("FAIL starve_relief: lsu_grants=%0d alu_wait=%0d, want 4/0", lsu_grants, dut.alu_wait_q);
                        end
                    end else begin
                        lsu_grants++;
                    end
                end
            end
        end
        idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL starve_timeout: %0d completions missing, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [15:0] c0;
        drive_alu(5'd9, 32'hC0DE_0009);
        tick();
        idle();
        tick();
        checks++;
        if (o_ret_valid !== 1'b1 || o_ret_data !== 32'hC0DE_0009) begin
            errors++;
            $display("FAIL stall_setup: valid=%b data=%h, want 1/c0de0009", o_ret_valid, o_ret_data);
        end
        c0 = o_conflict_cnt;
        for (int i = 0; i < 2; i++) begin
            idle();
            i_stall = 1'b1;
            drive_alu(5'(20 + i), 32'hA000 + i);
            drive_lsu(5'(24 + i), 32'hB000 + i);
            tick();
        end
        sb.push_back(mk_lsu_exp(5'd24, 32'hB000));
        sb.push_back(mk_lsu_exp(5'd25, 32'hB001));
        sb.push_back(mk_alu_exp(5'd20, 32'hA000));
        sb.push_back(mk_alu_exp(5'd21, 32'hA001));
        idle();
        i_stall = 1'b1;
        checks++;
        if (o_alu_ready !== 1'b0 || o_lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: alu_rdy=%b lsu_rdy=%b, want 0/0", o_alu_ready, o_lsu_ready);
        end
        tick();
        checks++;
        if (o_ret_valid !== 1'b1 || o_ret_data !== 32'hC0DE_0009 || o_conflict_cnt !== c0) begin
            errors++;
            $display("FAIL stall_hold: valid=%b data=%h cnt=%0d, want 1/c0de0009/%0d", o_ret_valid, o_ret_data, o_conflict_cnt, c0);
        end
        i_stall = 1'b0;
        for (int c = 0; c < 10 && sb.size() != 0; c++) begin
            tick();
            if (o_ret_valid) begin
                e = sb.pop_front();
                checks++;
                if (o_ret_uop !== e.uop || o_ret_data !== e.data) begin
                    errors++;
                    $display("FAIL stall_drain: rd=%0d data=%h, want rd=%0d data=%h", o_ret_uop.rd, o_ret_data, e.uop.rd, e.data);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stall_timeout: %0d completions missing, want 0", sb.size());
            sb.delete();
        end
        checks++;
        if (o_conflict_cnt !== c0 + 16'd2) begin
            errors++;
            $display("FAIL stall_count: cnt=%0d, want %0d", o_conflict_cnt, c0 + 16'd2);
        end
        tick();
    endtask

    task automatic test_flush();
        drive_lsu(5'd3, 32'hF00D_0003);
        tick();
        idle();
        tick();
        for (int i = 0; i < 2; i++) begin
            idle();
            i_stall = 1'b1;
            drive_alu(5'(12 + i), 32'hD000 + i);
            drive_lsu(5'(16 + i), 32'hE000 + i);
            tick();
        end
        idle();
        checks++;
        if (o_ret_valid !== 1'b1 || o_alu_ready !== 1'b0 || o_lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup: valid=%b alu_rdy=%b lsu_rdy=%b, want 1/0/0", o_ret_valid, o_alu_ready, o_lsu_ready);
        end
        i_stall = 1'b1;
        i_flush = 1'b1;
        drive_alu(5'd31, 32'hDEAD_BEEF);
        tick();
        idle();
        checks++;
        if (o_ret_valid !== 1'b0 || o_busy !== 1'b0 || o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: valid=%b busy=%b alu_rdy=%b lsu_rdy=%b, want 0/0/1/1", o_ret_valid, o_busy, o_alu_ready, o_lsu_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_ret_valid !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL flush_dropped: valid=%b busy=%b rd=%0d, want 0/0", o_ret_valid, o_busy, o_ret_uop.rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            idle();
            i_stall = 1'b1;
            drive_alu(5'(1 + i), 32'h1000 + i);
            drive_lsu(5'(3 + i), 32'h2000 + i);
            tick();
        end
        idle();
        tick();
        checks++;
        if (o_ret_valid !== 1'b1 || o_conflict_cnt === 16'h0) begin
            errors++;
            $display("FAIL rstmid_setup: valid=%b cnt=%0d, want 1/nonzero", o_ret_valid, o_conflict_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_ret_valid !== 1'b0 || o_ret_data !== 32'h0 || o_conflict_cnt !== 16'h0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b data=%h cnt=%0d busy=%b, want 0/0/0/0", o_ret_valid, o_ret_data, o_conflict_cnt, o_busy);
        end
        checks++;
        if (o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: alu_rdy=%b lsu_rdy=%b, want 1/1", o_alu_ready, o_lsu_ready);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (o_ret_valid !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale: valid=%b busy=%b rd=%0d, want 0/0", o_ret_valid, o_busy, o_ret_uop.rd);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_contention();
        test_starve();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
